// File: rtl/psum_drain_ctrl.sv
// Drains the psum memory after accumulation: streams every word out on valid/ready and clears it behind the read.
// Optional macro PSUM_DRAIN_RELU_EN applies a per-lane signed ReLU to drained words at FIFO push.
module psum_drain_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int BIT_WIDTH  = 8,
    parameter int MEM_DELAY  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
    input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
    output logic [ADDR_WIDTH-1:0] memctrl0_radd,
    output logic                  memctrl0_rden,
    input  logic [DATA_WIDTH-1:0] memctrl0_odat,
    input  logic                  memctrl0_ovld,
    output logic [ADDR_WIDTH-1:0] memctrl0_wadd,
    output logic                  memctrl0_wren,
    output logic [DATA_WIDTH-1:0] memctrl0_idat,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LANES = DATA_WIDTH / BIT_WIDTH;
`ifdef PSUM_DRAIN_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_DONE} state_t;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = w;
        for (int l = 0; l < LANES; l++) begin
            if (RELU_EN && w[l*BIT_WIDTH + BIT_WIDTH - 1]) begin
                r[l*BIT_WIDTH +: BIT_WIDTH] = '0;
            end
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [REG_WIDTH-1:0]  wmax_q, wmax_d;
    logic [REG_WIDTH-1:0]  word_q, word_d;
    logic [15:0]           gmax_q, gmax_d;
    logic [15:0]           group_q, group_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH:0]   fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   fifo_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] apipe_q [MEM_DELAY];
    logic [ADDR_WIDTH-1:0] apipe_d [MEM_DELAY];
    logic [MEM_DELAY-1:0]  lpipe_q, lpipe_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] wadd_q, wadd_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [CNT_W:0]        occupancy;
    logic                  credit;
    logic                  rden;
    logic                  last_issue;
    logic                  ovld_ok;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH:0]   head;
    logic [15:0]           kernels;
    logic [15:0]           gmax_start;
    logic                  unused_kshape;

    assign unused_kshape = ^i_conf_kernelshape[15:0];
    assign kernels       = i_conf_kernelshape[31:16];
    // Fewer than four kernels still occupies one group rather than wrapping to 0xFFFF.
    assign gmax_start    = (kernels < 16'd4) ? 16'd0 : ((kernels >> 2) - 16'd1);

    // Reads are only issued while every in-flight word is guaranteed a FIFO slot.
    assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign credit     = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign rden       = (state_q == S_ISSUE) && credit;
    assign last_issue = rden && (word_q == wmax_q) && (group_q == gmax_q);
    assign ovld_ok    = memctrl0_ovld && (inflight_q != '0);
    assign push       = ovld_ok;
    assign pop        = (fifo_cnt_q != '0) && i_rdy;
    assign head       = fifo_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        wmax_d     = wmax_q;
        word_d     = word_q;
        gmax_d     = gmax_q;
        group_d    = group_q;
        addr_d     = addr_q;
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_d     = fifo_q;
        done_d     = done_q;
        err_d      = err_q | (memctrl0_ovld && (inflight_q == '0));
        wren_d     = ovld_ok;
        wadd_d     = ovld_ok ? apipe_q[MEM_DELAY-1] : wadd_q;

        apipe_d[0] = addr_q;
        lpipe_d[0] = last_issue;
        for (int i = 1; i < MEM_DELAY; i++) begin
            apipe_d[i] = apipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end

        case ({rden, ovld_ok})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = {lpipe_q[MEM_DELAY-1], relu(memctrl0_odat)};
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    wmax_d  = i_conf_outputsize;
                    gmax_d  = gmax_start;
                    word_d  = '0;
                    group_d = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rden) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (word_q == wmax_q) begin
                        word_d  = '0;
                        group_d = group_q + 16'd1;
                    end else begin
                        word_d = word_q + REG_WIDTH'(1);
                    end
                    if (last_issue) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Finished once the final word leaves the FIFO and nothing is still in flight.
                if ((inflight_q == '0) &&
                    ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wmax_q     <= '0;
            word_q     <= '0;
            gmax_q     <= '0;
            group_q    <= '0;
            addr_q     <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            for (int i = 0; i < MEM_DELAY; i++) apipe_q[i] <= '0;
            lpipe_q    <= '0;
            wren_q     <= 1'b0;
            wadd_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wmax_q     <= wmax_d;
            word_q     <= word_d;
            gmax_q     <= gmax_d;
            group_q    <= group_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_q     <= fifo_d;
            apipe_q    <= apipe_d;
            lpipe_q    <= lpipe_d;
            wren_q     <= wren_d;
            wadd_q     <= wadd_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign memctrl0_radd = addr_q;
    assign memctrl0_rden = rden;
    assign memctrl0_wren = wren_q;
    assign memctrl0_wadd = wadd_q;
    assign memctrl0_idat = '0;
    assign o_vld         = (fifo_cnt_q != '0);
    assign o_dat         = o_vld ? head[DATA_WIDTH-1:0] : '0;
    assign o_last        = o_vld & head[DATA_WIDTH];
    assign o_busy        = (state_q == S_ISSUE) || (state_q == S_FLUSH);
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed self-checking bench for psum_drain_ctrl with a MEM_DELAY=2 psum memory model.
module tb_psum_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_conf_outputsize = '0;
    logic [31:0] i_conf_kernelshape = '0;
    logic [31:0] memctrl0_radd;
    logic        memctrl0_rden;
    logic [31:0] memctrl0_odat;
    logic        memctrl0_ovld;
    logic [31:0] memctrl0_wadd;
    logic        memctrl0_wren;
    logic [31:0] memctrl0_idat;
    logic [31:0] o_dat;
    logic        o_vld;
    logic        i_rdy = 1'b1;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int tests_run = 0;
    int tests_failed = 0;

    psum_drain_ctrl dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_conf_outputsize(i_conf_outputsize), .i_conf_kernelshape(i_conf_kernelshape),
        .memctrl0_radd(memctrl0_radd), .memctrl0_rden(memctrl0_rden),
        .memctrl0_odat(memctrl0_odat), .memctrl0_ovld(memctrl0_ovld),
        .memctrl0_wadd(memctrl0_wadd), .memctrl0_wren(memctrl0_wren),
        .memctrl0_idat(memctrl0_idat), .o_dat(o_dat), .o_vld(o_vld), .i_rdy(i_rdy),
        .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Memory model: 64 words, read data returned two cycles after rden, clear-writes applied.
    logic [31:0] mem [64];
    logic        load_req = 1'b0;
    int          load_kind = 0;
    logic        force_ovld = 1'b0;
    logic [31:0] force_dat = '0;
    logic [1:0]  pv;
    logic [31:0] pd0, pd1;

    function automatic logic [31:0] load_val(input int kind, input int i);
        if (kind == 0) return 32'(i + 1);
        if (kind == 1) return 32'h80FF7F01;
        return 32'(3 * i + 7);
    endfunction

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= load_val(load_kind, i);
        end else if (memctrl0_wren) begin
            mem[memctrl0_wadd[5:0]] <= memctrl0_idat;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0; pd0 <= '0; pd1 <= '0;
        end else begin
            pv  <= {pv[0], memctrl0_rden};
            pd0 <= mem[memctrl0_radd[5:0]];
            pd1 <= pd0;
        end
    end

    assign memctrl0_ovld = pv[1] | force_ovld;
    assign memctrl0_odat = force_ovld ? force_dat : pd1;

    // Monitor: records handshakes, reads and clear-writes, and tracks credit occupancy.
    int          cyc = 0;
    logic [31:0] out_dat [$];
    logic        out_last [$];
    int          out_cyc [$];
    logic [31:0] rd_addr [$];
    int          rd_cyc [$];
    logic [31:0] wr_addr [$];
    int          outst = 0, occ = 0, max_occ = 0, idat_bad = 0, done_cyc = 0;
    logic        done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            outst <= 0;
            occ   <= 0;
        end else begin
            if (memctrl0_rden) begin rd_addr.push_back(memctrl0_radd); rd_cyc.push_back(cyc); end
            if (o_vld && i_rdy) begin
                out_dat.push_back(o_dat); out_last.push_back(o_last); out_cyc.push_back(cyc);
            end
            if (memctrl0_wren) begin
                wr_addr.push_back(memctrl0_wadd);
                if (memctrl0_idat != 0) idat_bad <= idat_bad + 1;
            end
            outst <= outst + (memctrl0_rden ? 1 : 0) - ((memctrl0_ovld && outst > 0) ? 1 : 0);
            occ   <= occ + ((memctrl0_ovld && outst > 0) ? 1 : 0) - ((o_vld && i_rdy) ? 1 : 0);
            if (outst + occ > max_occ) max_occ <= outst + occ;
        end
        if (o_done && !done_prev) done_cyc <= cyc;
        done_prev <= o_done;
    end

    task automatic load_mem(input int kind);
        @(posedge clk); #1 load_kind = kind; load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic start_drain(input logic [31:0] osz, input logic [31:0] ks);
        @(posedge clk); #1 i_start = 1'b1; i_conf_outputsize = osz; i_conf_kernelshape = ks;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (o_done !== 1'b1 && c < budget) begin @(posedge clk); #1; c++; end
        tests_run++;
        if (o_done !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL done_timeout: o_done=%b after %0d cycles, expected 1", o_done, c);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({o_vld, o_busy, o_done, o_err, memctrl0_rden, memctrl0_wren, o_last} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: vld,busy,done,err,rden,wren,last=%b expected 0000000",
                     {o_vld, o_busy, o_done, o_err, memctrl0_rden, memctrl0_wren, o_last});
        end
        tests_run++;
        if (o_dat !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL reset_o_dat: got %h expected 00000000", o_dat);
        end
    endtask

    task automatic test_basic;
        int ob, rb, wb;
        load_mem(0);
        i_rdy = 1'b1;
        ob = out_dat.size(); rb = rd_cyc.size(); wb = wr_addr.size();
        start_drain(32'd3, 32'h0004_0000);
        tests_run++;
        if (memctrl0_rden !== 1'b1 || memctrl0_radd !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL first_rden: rden=%b radd=%0d expected rden=1 radd=0", memctrl0_rden, memctrl0_radd);
        end
        wait_done(100);
        tests_run++;
        if (out_dat.size() - ob !== 4) begin
            tests_failed++; $display("[TB] FAIL basic_count: got %0d words expected 4", out_dat.size() - ob);
        end
        for (int i = 0; i < 4 && ob + i < out_dat.size(); i++) begin
            tests_run++;
            if (out_dat[ob+i] !== 32'(i + 1) || out_last[ob+i] !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL basic_word%0d: got %h last=%b expected %h last=%b",
                         i, out_dat[ob+i], out_last[ob+i], i + 1, (i == 3));
            end
        end
        if (out_cyc.size() >= ob + 4 && rd_cyc.size() > rb) begin
            tests_run++;
            if (out_cyc[ob] - rd_cyc[rb] !== 3) begin
                tests_failed++; $display("[TB] FAIL rden_to_vld: got %0d cycles expected 3", out_cyc[ob] - rd_cyc[rb]);
            end
            tests_run++;
            if (out_cyc[ob+3] - out_cyc[ob] !== 3) begin
                tests_failed++; $display("[TB] FAIL throughput: span %0d cycles expected 3", out_cyc[ob+3] - out_cyc[ob]);
            end
            tests_run++;
            if (done_cyc !== out_cyc[ob+3] + 1) begin
                tests_failed++; $display("[TB] FAIL done_timing: o_done rose at %0d expected %0d", done_cyc, out_cyc[ob+3] + 1);
            end
        end
        tests_run++;
        if (wr_addr.size() - wb !== 4) begin
            tests_failed++; $display("[TB] FAIL basic_wren_count: got %0d expected 4", wr_addr.size() - wb);
        end
        for (int i = 0; i < 4 && wb + i < wr_addr.size(); i++) begin
            tests_run++;
            if (wr_addr[wb+i] !== 32'(i) || mem[i] !== 32'h0) begin
                tests_failed++;
                $display("[TB] FAIL basic_clear%0d: wadd=%0d mem=%h expected wadd=%0d mem=0", i, wr_addr[wb+i], mem[i], i);
            end
        end
        tests_run++;
        if (mem[4] !== 32'd5 || idat_bad !== 0) begin
            tests_failed++; $display("[TB] FAIL basic_untouched: mem[4]=%h idat_bad=%0d expected 5 and 0", mem[4], idat_bad);
        end
        tests_run++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL basic_status: done=%b busy=%b expected 1 0", o_done, o_busy);
        end
    endtask

    task automatic test_groups;
        int ob, rb;
        load_mem(2);
        ob = out_dat.size(); rb = rd_addr.size();
        start_drain(32'd1, 32'h0008_0000);
        wait_done(100);
        tests_run++;
        if (rd_addr.size() - rb !== 4 || out_dat.size() - ob !== 4) begin
            tests_failed++;
            $display("[TB] FAIL groups_count: reads=%0d words=%0d expected 4 4", rd_addr.size() - rb, out_dat.size() - ob);
        end
        for (int i = 0; i < 4 && ob + i < out_dat.size() && rb + i < rd_addr.size(); i++) begin
            tests_run++;
            if (rd_addr[rb+i] !== 32'(i) || out_dat[ob+i] !== 32'(3*i + 7) || out_last[ob+i] !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL groups_word%0d: addr=%0d dat=%h last=%b expected addr=%0d dat=%h last=%b",
                         i, rd_addr[rb+i], out_dat[ob+i], out_last[ob+i], i, 3*i + 7, (i == 3));
            end
        end
        ob = out_dat.size();
        start_drain(32'd1, 32'h0008_0000);
        wait_done(100);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (ob + i >= out_dat.size() || out_dat[ob+i] !== 32'h0) begin
                tests_failed++; $display("[TB] FAIL redrain_word%0d: missing or nonzero, expected 00000000", i);
            end
        end
        ob = out_dat.size();
        start_drain(32'd1, 32'h0002_0000);
        wait_done(100);
        tests_run++;
        if (out_dat.size() - ob !== 2 || out_last[out_last.size()-1] !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL few_kernels: got %0d words expected 2 ending with last", out_dat.size() - ob);
        end
    endtask

    task automatic test_backpressure;
        int ob, rb, wb, c;
        load_mem(2);
        i_rdy = 1'b1;
        ob = out_dat.size(); rb = rd_cyc.size(); wb = wr_addr.size();
        start_drain(32'd15, 32'h0004_0000);
        c = 0;
        while (o_done !== 1'b1 && c < 400) begin @(posedge clk); #1 i_rdy = ~i_rdy; c++; end
        i_rdy = 1'b1;
        wait_done(20);
        tests_run++;
        if (out_dat.size() - ob !== 16 || wr_addr.size() - wb !== 16) begin
            tests_failed++;
            $display("[TB] FAIL bp_count: words=%0d writes=%0d expected 16 16", out_dat.size() - ob, wr_addr.size() - wb);
        end
        for (int i = 0; i < 16 && ob + i < out_dat.size(); i++) begin
            tests_run++;
            if (out_dat[ob+i] !== 32'(3*i + 7) || out_last[ob+i] !== (i == 15)) begin
                tests_failed++;
                $display("[TB] FAIL bp_word%0d: got %h last=%b expected %h last=%b", i, out_dat[ob+i], out_last[ob+i], 3*i + 7, (i == 15));
            end
        end
        tests_run++;
        if (rd_cyc.size() - rb !== 16 || rd_cyc[rd_cyc.size()-1] - rd_cyc[rb] <= 15) begin
            tests_failed++; $display("[TB] FAIL bp_stall: %0d reads, no credit stall seen, expected 16 reads with stalls", rd_cyc.size() - rb);
        end
        tests_run++;
        if (max_occ > 4) begin
            tests_failed++; $display("[TB] FAIL credit_bound: inflight+fifo reached %0d expected <= 4", max_occ);
        end
    endtask

    task automatic test_relu;
        int ob;
        logic [31:0] exp_w;
`ifdef PSUM_DRAIN_RELU_EN
        exp_w = 32'h00007F01;
`else
        exp_w = 32'h80FF7F01;
`endif
        load_mem(1);
        ob = out_dat.size();
        start_drain(32'd0, 32'h0004_0000);
        wait_done(100);
        tests_run++;
        if (ob >= out_dat.size() || out_dat[ob] !== exp_w) begin
            tests_failed++; $display("[TB] FAIL relu_word: got %h expected %h", (ob < out_dat.size()) ? out_dat[ob] : 32'hx, exp_w);
        end
        tests_run++;
        if (mem[0] !== 32'h0 || mem[1] !== 32'h80FF7F01) begin
            tests_failed++; $display("[TB] FAIL relu_clear: mem0=%h mem1=%h expected 00000000 80ff7f01", mem[0], mem[1]);
        end
    endtask

    task automatic test_reset_mid;
        int ob, rb, c;
        load_mem(2);
        i_rdy = 1'b1;
        ob = out_dat.size();
        start_drain(32'd15, 32'h0004_0000);
        c = 0;
        while (out_dat.size() < ob + 5 && c < 100) begin @(posedge clk); #1; c++; end
        tests_run++;
        if (out_dat.size() < ob + 5) begin
            tests_failed++; $display("[TB] FAIL mid_progress: got %0d words expected 5", out_dat.size() - ob);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({o_vld, o_busy, o_done, o_err, memctrl0_rden, memctrl0_wren, o_last} !== 7'b0 || o_dat !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: ctrl=%b dat=%h expected 0000000 00000000",
                     {o_vld, o_busy, o_done, o_err, memctrl0_rden, memctrl0_wren, o_last}, o_dat);
        end
        @(posedge clk); #1 rst = 1'b0;
        ob = out_dat.size(); rb = rd_addr.size();
        start_drain(32'd15, 32'h0004_0000);
        tests_run++;
        if (memctrl0_rden !== 1'b1 || memctrl0_radd !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL restart_addr: rden=%b radd=%0d expected 1 0", memctrl0_rden, memctrl0_radd);
        end
        start_drain(32'd3, 32'h0004_0000);
        wait_done(200);
        tests_run++;
        if (rd_addr.size() - rb !== 16 || out_dat.size() - ob !== 16) begin
            tests_failed++;
            $display("[TB] FAIL restart_count: reads=%0d words=%0d expected 16 16", rd_addr.size() - rb, out_dat.size() - ob);
        end
        for (int i = 0; i < 16 && ob + i < out_dat.size(); i++) begin
            if (i < 5 || i >= 10) begin
                tests_run++;
                if (out_dat[ob+i] !== ((i < 5) ? 32'h0 : 32'(3*i + 7)) || out_last[ob+i] !== (i == 15)) begin
                    tests_failed++;
                    $display("[TB] FAIL restart_word%0d: got %h last=%b expected %h last=%b",
                             i, out_dat[ob+i], out_last[ob+i], (i < 5) ? 0 : 3*i + 7, (i == 15));
                end
            end
        end
    endtask

    task automatic test_err;
        int wb, ob;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        tests_run++;
        if (o_err !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL err_clear: got %b expected 0", o_err);
        end
        wb = wr_addr.size(); ob = out_dat.size();
        @(posedge clk); #1 force_ovld = 1'b1; force_dat = 32'h12345678;
        @(posedge clk); #1 force_ovld = 1'b0;
        tests_run++;
        if (o_err !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL err_set: got %b expected 1", o_err);
        end
        repeat (3) begin @(posedge clk); #1; end
        tests_run++;
        if (o_vld !== 1'b0 || out_dat.size() !== ob || wr_addr.size() !== wb || o_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_drop: vld=%b pops=%0d writes=%0d err=%b expected 0 0 0 1",
                     o_vld, out_dat.size() - ob, wr_addr.size() - wb, o_err);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_groups;
        test_backpressure;
        test_relu;
        test_reset_mid;
        test_err;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
